gcd_nibble_driver: RTL and testbench

Synthesizable operand-entry initiator for the GCD calculator's 4-bit switch / enter-key input port. It accepts two 8-bit two's-complement operands over a valid/ready handshake. It replays them as four nibbles on `sw_out`, each qualified by a timed `key_enter` pulse, high nibble first, operand A before operand B. After a settle interval it samples the calculator's `led` result and returns it over a second valid/ready handshake. It sits between a host or self-test controller and the `gcd` block, replacing manual switch entry.

---
 rtl/gcd_nibble_driver.sv | 206 ++++++++++++++++++++
 tb/tb_gcd_nibble_driver.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_nibble_driver.sv
// Purpose: replays two 8-bit operands to the GCD calculator as four timed nibble/enter-key strokes, then returns its LED result.
// Latency: 4*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+RESULT_WAIT cycles from acceptance to rsp_valid (+PULSE_CYC+HOLD_CYC with GCD_DRV_AUTOCLR_EN).
// Backpressure: req_ready only in IDLE; rsp_valid holds with a stable rsp_result until rsp_ready. Optional macro: GCD_DRV_AUTOCLR_EN (clear-key stroke before entry).
module gcd_nibble_driver #(
    parameter int SETUP_CYC   = 50,
    parameter int PULSE_CYC   = 50,
    parameter int HOLD_CYC    = 50,
    parameter int RESULT_WAIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [3:0] sw_out,
    output logic       key_enter,
    output logic       key_clr,
    input  logic [7:0] led_in,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       busy
);

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_HW = (HOLD_CYC > RESULT_WAIT) ? HOLD_CYC : RESULT_WAIT;
    localparam int MAX_P  = (MAX_SP > MAX_HW) ? MAX_SP : MAX_HW;
    localparam int CW     = $clog2(MAX_P) + 1;

    // Counter reload values: a state lasting N cycles counts N-1 down to 0.
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] WAIT_LD  = CW'(RESULT_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLR_P,
        CLR_H,
        SETUP,
        PULSE,
        HOLD,
        WAIT_RES,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [15:0]   shadow;
    logic [15:0]   shadow_nxt;
    logic [3:0]    sw_nxt;

    // Nibble order on the switches: A high, A low, B high, B low.
    function automatic logic [3:0] nib_sel(input logic [15:0] s, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = s[15:12];
            2'd1:    n = s[11:8];
            2'd2:    n = s[7:4];
            default: n = s[3:0];
        endcase
        return n;
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter reloads, nibble index and the next switch value.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        sw_nxt     = sw_out;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    shadow_nxt = {op_a, op_b};
                    idx_nxt    = 2'd0;
`ifdef GCD_DRV_AUTOCLR_EN
                    state_nxt  = CLR_P;
                    cnt_nxt    = PULSE_LD;
                    sw_nxt     = 4'd0;
`else
                    state_nxt  = SETUP;
                    cnt_nxt    = SETUP_LD;
                    sw_nxt     = op_a[7:4];
`endif
                end
            end
            CLR_P: begin
                if (cnt == '0) begin
                    state_nxt = CLR_H;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            CLR_H: begin
                if (cnt == '0) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                    sw_nxt    = nib_sel(shadow, 2'd0);
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (idx == 2'd3) begin
                    state_nxt = WAIT_RES;
                    cnt_nxt   = WAIT_LD;
                end else begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                    sw_nxt    = nib_sel(shadow, idx + 2'd1);
                end
            end
            WAIT_RES: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered datapath and outputs; outputs track the state being entered so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 16'd0;
            sw_out     <= 4'd0;
            key_enter  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'd0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shadow    <= shadow_nxt;
            sw_out    <= sw_nxt;
            key_enter <= (state_nxt == PULSE);
            rsp_valid <= (state_nxt == RESP);
            if ((state == WAIT_RES) && (state_nxt == RESP)) begin
                rsp_result <= led_in;
            end
        end
    end

`ifdef GCD_DRV_AUTOCLR_EN
    // Clear key is high exactly while the clear stroke is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_clr <= 1'b0;
        end else begin
            key_clr <= (state_nxt == CLR_P);
        end
    end
`else
    assign key_clr = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_nibble_driver.sv
module tb_gcd_nibble_driver;

    localparam int SETUP_CYC   = 50;
    localparam int PULSE_CYC   = 50;
    localparam int HOLD_CYC    = 50;
    localparam int RESULT_WAIT = 100;
`ifdef GCD_DRV_AUTOCLR_EN
    localparam int EXP_LAT = 4 * (SETUP_CYC + PULSE_CYC + HOLD_CYC) + RESULT_WAIT + PULSE_CYC + HOLD_CYC;
`else
    localparam int EXP_LAT = 4 * (SETUP_CYC + PULSE_CYC + HOLD_CYC) + RESULT_WAIT;
`endif

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] sw_out;
    logic       key_enter;
    logic       key_clr;
    logic [7:0] led_in;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;

    gcd_nibble_driver #(
        .SETUP_CYC  (SETUP_CYC),
        .PULSE_CYC  (PULSE_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .RESULT_WAIT(RESULT_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sw_out    (sw_out),
        .key_enter (key_enter),
        .key_clr   (key_clr),
        .led_in    (led_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference GCD of the magnitudes of two two's-complement bytes.
    function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        int t;
        x = int'($signed(a));
        y = int'($signed(b));
        if (x < 0) x = -x;
        if (y < 0) y = -y;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // Calculator model and line monitor: captures keyed nibbles, measures strokes, drives led_in.
    int          pulses = 0;
    int          minw = 1000000;
    int          maxw = 0;
    int          curw = 0;
    int          setup_min = 1000000;
    int          stable = 0;
    int          glitches = 0;
    int          low_run = 1000000;
    bit          after_pulse = 0;
    logic [15:0] nibs = 16'd0;
    logic [3:0]  prev_sw = 4'd0;
    logic        prev_key = 1'b0;
    logic        prev_clr = 1'b0;
    int          clr_cur = 0;
    int          clr_w = 0;
    int          clr_gap = 0;
    bit          clr_track = 0;
    int          clr_sw_bad = 0;
    bit          clr_seen = 0;

    initial led_in = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pulses = 0; minw = 1000000; maxw = 0; curw = 0; setup_min = 1000000;
            stable = 0; glitches = 0; low_run = 1000000; after_pulse = 0; nibs = 16'd0;
            prev_sw = sw_out; prev_key = 1'b0; prev_clr = 1'b0;
            clr_cur = 0; clr_w = 0; clr_gap = 0; clr_track = 0; clr_sw_bad = 0;
        end else begin
            if (!busy) begin
                pulses = 0; minw = 1000000; maxw = 0; setup_min = 1000000;
                glitches = 0; nibs = 16'd0; clr_w = 0; clr_gap = 0; clr_track = 0; clr_sw_bad = 0;
            end
            if (key_enter && !prev_key) begin
                pulses++;
                nibs = {nibs[11:0], sw_out};
                after_pulse = 1;
                if (stable < setup_min) setup_min = stable;
                if (pulses == 4) led_in <= gcd8(nibs[15:8], nibs[7:0]);
            end
            if (sw_out != prev_sw) begin
                if (key_enter || (after_pulse && low_run < HOLD_CYC)) glitches++;
                stable = 1;
            end else begin
                stable++;
            end
            low_run = key_enter ? 0 : low_run + 1;
            if (key_enter) curw++;
            if (!key_enter && prev_key) begin
                if (curw < minw) minw = curw;
                if (curw > maxw) maxw = curw;
                curw = 0;
            end
            if (key_clr) begin
                clr_seen = 1;
                clr_cur++;
                if (sw_out != 4'd0) clr_sw_bad++;
            end
            if (!key_clr && prev_clr) begin
                clr_w = clr_cur;
                clr_cur = 0;
                clr_track = 1;
                clr_gap = 1;
            end else if (clr_track) begin
                if (key_enter) clr_track = 0;
                else clr_gap++;
            end
            prev_sw  = sw_out;
            prev_key = key_enter;
            prev_clr = key_clr;
        end
    end

    // Present a request and hold it until accepted; afterwards scramble the operand lines.
    task automatic send_req(input logic [7:0] a, input logic [7:0] b, output bit ok);
        @(negedge clk);
        req_valid = 1'b1;
        op_a = a;
        op_b = b;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        ok = 0;
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                lat = cyc - acc_cyc;
                break;
            end
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op_a = 8'd0;
        op_b = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sw_out !== 4'd0) begin errors++; $display("FAIL reset_sw_out: got %b expected 0000", sw_out); end
        checks++; if (key_enter !== 1'b0) begin errors++; $display("FAIL reset_key_enter: got %b expected 0", key_enter); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_result !== 8'd0) begin errors++; $display("FAIL reset_rsp_result: got %h expected 00", rsp_result); end
    endtask

    task automatic test_negative_order();
        bit ok;
        int lat;
        send_req(8'hDE, 8'h11, ok);
        checks++; if (!ok) begin errors++; $display("FAIL neg_accept: got timeout expected acceptance"); end
        wait_rsp(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL neg_rsp: got timeout expected rsp_valid"); end
        checks++; if (nibs !== 16'hDE11) begin errors++; $display("FAIL neg_nibbles: got %h expected de11", nibs); end
        checks++; if (pulses != 4) begin errors++; $display("FAIL neg_pulse_count: got %0d expected 4", pulses); end
        checks++; if (minw != PULSE_CYC || maxw != PULSE_CYC) begin errors++; $display("FAIL neg_pulse_width: got %0d..%0d expected %0d", minw, maxw, PULSE_CYC); end
        checks++; if (setup_min < SETUP_CYC) begin errors++; $display("FAIL neg_setup: got %0d expected >= %0d", setup_min, SETUP_CYC); end
        checks++; if (glitches != 0) begin errors++; $display("FAIL neg_glitch: got %0d expected 0", glitches); end
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL neg_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (rsp_result !== 8'd17) begin errors++; $display("FAIL neg_result: got %0d expected 17", rsp_result); end
        take_rsp();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL neg_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        int bad;
        logic [7:0] r0;
        logic [7:0] a2;
        logic [7:0] b2;
        send_req(8'd15, 8'd25, ok);
        wait_rsp(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_rsp: got timeout expected rsp_valid"); end
        checks++; if (nibs !== 16'h0F19) begin errors++; $display("FAIL b2b_nibbles: got %h expected 0f19", nibs); end
        r0 = rsp_result;
        checks++; if (r0 !== 8'd5) begin errors++; $display("FAIL b2b_result: got %0d expected 5", r0); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== r0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_hold: got %0d unstable cycles expected 0", bad); end
        take_rsp();
        a2 = 8'($urandom);
        b2 = 8'($urandom);
        send_req(a2, b2, ok);
        checks++; if (!ok || acc_cyc - hs_cyc != 1) begin errors++; $display("FAIL b2b_gap: got %0d expected 1", acc_cyc - hs_cyc); end
        wait_rsp(lat, ok);
        checks++; if (rsp_result !== gcd8(a2, b2)) begin errors++; $display("FAIL b2b_second_result: got %0d expected %0d", rsp_result, gcd8(a2, b2)); end
        take_rsp();
    endtask

    task automatic test_random_operands();
        bit ok;
        int lat;
        logic [7:0] ta [8];
        logic [7:0] tb [8];
        ta[0] = 8'h00; tb[0] = 8'h80;
        ta[1] = 8'h80; tb[1] = 8'h80;
        ta[2] = 8'h00; tb[2] = 8'h00;
        for (int k = 3; k < 8; k++) begin
            ta[k] = 8'($urandom);
            tb[k] = 8'($urandom);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_req(ta[k], tb[k], ok);
            rsp_ready = 1'b1;
            wait_rsp(lat, ok);
            checks++; if (nibs !== {ta[k], tb[k]} || pulses != 4) begin errors++; $display("FAIL rnd_nibbles[%0d]: got %h/%0d expected %h/4", k, nibs, pulses, {ta[k], tb[k]}); end
            checks++; if (rsp_result !== gcd8(ta[k], tb[k])) begin errors++; $display("FAIL rnd_result[%0d]: got %0d expected %0d", k, rsp_result, gcd8(ta[k], tb[k])); end
            checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", k, lat, EXP_LAT); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_one_cycle_rsp[%0d]: got valid=%b busy=%b expected 0 0", k, rsp_valid, busy); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_busy_request();
        bit ok;
        int lat;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        send_req(a, b, ok);
        for (int i = 0; i < 3000 && cyc < acc_cyc + EXP_LAT - 60; i++) @(negedge clk);
        req_valid = 1'b1;
        op_a = 8'h7F;
        op_b = 8'($urandom);
        repeat (10) @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat, ok);
        checks++; if (rsp_result !== gcd8(a, b)) begin errors++; $display("FAIL busy_result: got %0d expected %0d", rsp_result, gcd8(a, b)); end
        checks++; if (pulses != 4 || nibs !== {a, b}) begin errors++; $display("FAIL busy_pulses: got %0d/%h expected 4/%h", pulses, nibs, {a, b}); end
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", lat, EXP_LAT); end
        take_rsp();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        int bad;
        send_req(8'($urandom), 8'($urandom), ok);
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pulses == 2 && key_enter) begin
                found = 1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_second_pulse: got timeout expected pulse"); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (key_enter !== 1'b0 || key_clr !== 1'b0) begin errors++; $display("FAIL rstmid_key_drop: got enter=%b clr=%b expected 0 0", key_enter, key_clr); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got ready=%b busy=%b expected 1 0", req_ready, busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (EXP_LAT + 50) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d active cycles expected 0", bad); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_autoclr();
`ifdef GCD_DRV_AUTOCLR_EN
        bit ok;
        int lat;
        send_req(8'h24, 8'h9C, ok);
        wait_rsp(lat, ok);
        checks++; if (clr_w != PULSE_CYC) begin errors++; $display("FAIL clr_width: got %0d expected %0d", clr_w, PULSE_CYC); end
        checks++; if (clr_gap != HOLD_CYC + SETUP_CYC) begin errors++; $display("FAIL clr_gap: got %0d expected %0d", clr_gap, HOLD_CYC + SETUP_CYC); end
        checks++; if (clr_sw_bad != 0) begin errors++; $display("FAIL clr_sw_zero: got %0d cycles nonzero expected 0", clr_sw_bad); end
        checks++; if (lat != EXP_LAT || rsp_result !== gcd8(8'h24, 8'h9C)) begin errors++; $display("FAIL clr_txn: got lat=%0d res=%0d expected %0d %0d", lat, rsp_result, EXP_LAT, gcd8(8'h24, 8'h9C)); end
        take_rsp();
`else
        checks++; if (clr_seen != 0) begin errors++; $display("FAIL clr_tied_low: got key_clr activity expected none"); end
`endif
    endtask

    initial begin
        test_reset();
        test_negative_order();
        test_back_to_back();
        test_random_operands();
        test_busy_request();
        test_reset_mid();
        test_autoclr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
